// File: rtl/motor_pkg.sv
// Shared motor constants: direction codes (common with the PWM driver), decoder states, quadrature phase helper.
// Pure definitions, no timing or flow-control behaviour.
package motor_pkg;

  localparam logic [1:0] DIR_FWD  = 2'b11;
  localparam logic [1:0] DIR_BWD  = 2'b00;
  localparam logic [1:0] DIR_HALT = 2'b01;

  typedef enum logic {INIT, RUN} dec_state_t;

  // Position of an {A,B} level along the forward cycle 00->01->11->10.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Two-flop synchroniser plus persistence filter for one encoder channel.
// Pin edge reaches dout after 2+FILT_LEN cycles; pulses shorter than FILT_LEN synced cycles are dropped; no backpressure.
module enc_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dout  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != dout) begin
        if (cnt == CNT_LAST) begin
          dout <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/motor_encoder_reader.sv
// Quadrature encoder reader: x4 position, windowed signed speed, measured direction, error count; optional stall flag
// under `MOTOR_STALL_DETECT_EN. Step visible on position one cycle after the filtered edge; no backpressure.
module motor_encoder_reader
  import motor_pkg::*;
#(
  parameter int FILT_LEN      = 4,
  parameter int GATE_CYCLES   = 1000,
  parameter int POS_W         = 16,
  parameter int SPD_W         = 12,
  parameter int STALL_WINDOWS = 5
) (
  input  logic             clk_100kHz,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             pos_clr,
  input  logic [1:0]       cmd_dir,
  output logic [POS_W-1:0] position,
  output logic [SPD_W-1:0] speed,
  output logic             speed_valid,
  output logic [1:0]       meas_dir,
  output logic [7:0]       err_cnt,
  output logic             stall
);

  localparam int IW = $clog2(FILT_LEN + 3);
  localparam logic [IW-1:0] INIT_LAST = IW'(FILT_LEN + 2);
  localparam int WW = $clog2(GATE_CYCLES);
  localparam logic [WW-1:0] WIN_LAST = WW'(GATE_CYCLES - 1);
  localparam logic signed [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic signed [SPD_W-1:0] SPD_MIN = {1'b1, {(SPD_W-2){1'b0}}, 1'b1};

  logic filt_a;
  logic filt_b;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk_100kHz),
    .rst  (rst),
    .din  (enc_a),
    .dout (filt_a)
  );

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk_100kHz),
    .rst  (rst),
    .din  (enc_b),
    .dout (filt_b)
  );

  dec_state_t              state_q;
  dec_state_t              state_d;
  logic [IW-1:0]           init_cnt;
  logic [1:0]              prev_ab;
  logic [1:0]              cur_ab;
  logic [1:0]              phase_diff;
  logic                    step_inc;
  logic                    step_dec;
  logic                    step_err;
  logic [WW-1:0]           win_cnt;
  logic                    win_close;
  logic signed [SPD_W-1:0] acc;
  logic signed [SPD_W-1:0] acc_next;

  assign cur_ab     = {filt_a, filt_b};
  assign phase_diff = quad_phase(cur_ab) - quad_phase(prev_ab);
  assign win_close  = (win_cnt == '0);

  always_comb begin
    state_d  = state_q;
    step_inc = 1'b0;
    step_dec = 1'b0;
    step_err = 1'b0;
    case (state_q)
      INIT: begin
        if (init_cnt == INIT_LAST) state_d = RUN;
      end
      RUN: begin
        case (phase_diff)
          2'd1:    step_inc = 1'b1;
          2'd3:    step_dec = 1'b1;
          2'd2:    step_err = 1'b1;
          default: ;
        endcase
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_100kHz) begin
    if (rst) begin
      state_q  <= INIT;
      init_cnt <= '0;
      prev_ab  <= 2'b00;
    end else begin
      state_q <= state_d;
      prev_ab <= cur_ab;
      if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_100kHz) begin
    if (rst) begin
      position <= '0;
      err_cnt  <= '0;
    end else begin
      if (pos_clr)       position <= '0;
      else if (step_inc) position <= position + POS_W'(1);
      else if (step_dec) position <= position - POS_W'(1);
      if (step_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Saturating accumulator; the closing window includes the step of its last cycle.
  always_comb begin
    acc_next = acc;
    if (step_inc && acc != SPD_MAX)      acc_next = acc + SPD_W'(1);
    else if (step_dec && acc != SPD_MIN) acc_next = acc - SPD_W'(1);
  end

  always_ff @(posedge clk_100kHz) begin
    if (rst) begin
      win_cnt     <= WIN_LAST;
      acc         <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      meas_dir    <= DIR_HALT;
    end else if (win_close) begin
      win_cnt     <= WIN_LAST;
      acc         <= '0;
      speed       <= acc_next;
      speed_valid <= 1'b1;
      if (acc_next > 0)      meas_dir <= DIR_FWD;
      else if (acc_next < 0) meas_dir <= DIR_BWD;
      else                   meas_dir <= DIR_HALT;
    end else begin
      win_cnt     <= win_cnt - 1'b1;
      acc         <= acc_next;
      speed_valid <= 1'b0;
    end
  end

`ifdef MOTOR_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_WINDOWS + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_WINDOWS);

  logic [SW-1:0] stall_cnt;

  always_ff @(posedge clk_100kHz) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (win_close) begin
      if ((cmd_dir == DIR_FWD || cmd_dir == DIR_BWD) && acc_next == '0) begin
        if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign stall = (stall_cnt == STALL_MAX);
`else
  logic unused_cmd_dir;
  assign unused_cmd_dir = ^cmd_dir;
  assign stall          = 1'b0;
`endif

endmodule
